// File: rtl/uart_rx.sv
// UART receiver: deserialises LSB-first frames from a 16x oversampled line,
// pulsing o_rx_done for good frames and o_frame_err when the stop bit is low.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);
    localparam int               BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [4:0]       MID_TICK  = 5'd7;
    localparam logic [4:0]       BIT_TICK  = 5'd15;
    localparam logic [4:0]       STOP_LAST = 5'(STOP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                r_state;
    logic [4:0]            r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_sync_0;
    logic                  r_sync_1;
    logic                  w_rx_s;

    assign w_rx_s = r_sync_1;

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync_0 <= 1'b1;
            r_sync_1 <= 1'b1;
        end else begin
            r_sync_0 <= i_rx;
            r_sync_1 <= r_sync_0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                    end
                end
                // Re-check the line mid start bit so short glitches are dropped.
                START: begin
                    if (i_tick) begin
                        if (r_tick_cnt == MID_TICK) begin
                            if (!w_rx_s) begin
                                r_state    <= DATA;
                                r_tick_cnt <= '0;
                                r_bit_cnt  <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (r_tick_cnt == BIT_TICK) begin
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (r_tick_cnt == STOP_LAST) begin
                            if (w_rx_s) begin
                                o_data    <= r_shift;
                                o_rx_done <= 1'b1;
                                r_state   <= IDLE;
                            end else begin
                                o_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 5'd1;
                        end
                    end
                end
                // A line held low after a bad stop bit must not start new frames.
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit against a fast
// tick (one per 4 clocks) and outputs are tracked by a negedge monitor.
module tb_uart_rx;
    localparam int DATA_BITS  = 8;
    localparam int STOP_TICKS = 16;
    localparam int LATENCY    = 8 + 16 * DATA_BITS + STOP_TICKS;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 tick  = 1'b0;
    logic                 rx    = 1'b1;
    logic [DATA_BITS-1:0] oData;
    logic                 oRxDone;
    logic                 oFrameErr;

    logic                 tickEn    = 1'b1;
    logic [1:0]           tickPhase = 2'd0;
    int                   tickCount = 0;
    int                   frameStartTick = 0;

    int                   checks = 0;
    int                   passed = 0;

    int                   doneCount = 0;
    int                   errCount = 0;
    int                   doneTick = 0;
    int                   bothHigh = 0;
    int                   widePulse = 0;
    int                   dataGlitch = 0;
    logic [DATA_BITS-1:0] lastData;
    logic [DATA_BITS-1:0] prevData;
    logic                 prevDone;
    logic                 prevErr;
    logic [DATA_BITS-1:0] rxLog[$];

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .STOP_TICKS(STOP_TICKS)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_tick     (tick),
        .i_rx       (rx),
        .o_data     (oData),
        .o_rx_done  (oRxDone),
        .o_frame_err(oFrameErr)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tickEn) begin
            tickPhase = tickPhase + 2'd1;
            tick = (tickPhase == 2'd3);
        end else begin
            tick = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (tick) tickCount++;
    end

    // Output monitor: records pulses and flags width, overlap and data-stability violations.
    always @(negedge clock) begin
        if (oRxDone) begin
            doneCount++;
            lastData = oData;
            doneTick = tickCount;
            rxLog.push_back(oData);
        end
        if (oFrameErr) errCount++;
        if (oRxDone && oFrameErr) bothHigh++;
        if ((oRxDone && prevDone) || (oFrameErr && prevErr)) widePulse++;
        if (!reset && !oRxDone && (oData !== prevData)) dataGlitch++;
        prevDone = oRxDone;
        prevErr  = oFrameErr;
        prevData = oData;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            while (!tick) @(posedge clock);
        end
    endtask

    task automatic sendBit(input logic value, input int ticks);
        @(negedge clock);
        rx = value;
        waitTicks(ticks);
    endtask

    task automatic sendFrame(input logic [DATA_BITS-1:0] data, input logic stopLow);
        @(negedge clock);
        rx = 1'b0;
        frameStartTick = tickCount;
        waitTicks(16);
        for (int i = 0; i < DATA_BITS; i++) sendBit(data[i], 16);
        sendBit(!stopLow, STOP_TICKS);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (oData !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", oData); else passed++;
        checks++; if (oRxDone !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", oRxDone); else passed++;
        checks++; if (oFrameErr !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", oFrameErr); else passed++;
        reset = 1'b0;
        waitTicks(4);
    endtask

    task automatic test_single_frame();
        int d0 = doneCount;
        int e0 = errCount;
        sendFrame(8'h55, 1'b0);
        waitTicks(2);
        checks++; if (doneCount - d0 !== 1) $display("[TB] FAIL single_done_count: got %0d expected 1", doneCount - d0); else passed++;
        checks++; if (lastData !== 8'h55) $display("[TB] FAIL single_data: got %h expected 55", lastData); else passed++;
        checks++; if (errCount - e0 !== 0) $display("[TB] FAIL single_err_count: got %0d expected 0", errCount - e0); else passed++;
        checks++; if (doneTick - frameStartTick !== LATENCY) $display("[TB] FAIL single_latency: got %0d ticks expected %0d", doneTick - frameStartTick, LATENCY); else passed++;
        checks++; if (oData !== 8'h55) $display("[TB] FAIL single_data_held: got %h expected 55", oData); else passed++;
    endtask

    task automatic test_back_to_back();
        int d0 = doneCount;
        int e0 = errCount;
        sendFrame(8'hA5, 1'b0);
        sendFrame(8'h3C, 1'b0);
        waitTicks(2);
        checks++; if (doneCount - d0 !== 2) $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneCount - d0); else passed++;
        checks++; if (rxLog[rxLog.size()-2] !== 8'hA5) $display("[TB] FAIL b2b_first: got %h expected a5", rxLog[rxLog.size()-2]); else passed++;
        checks++; if (rxLog[rxLog.size()-1] !== 8'h3C) $display("[TB] FAIL b2b_second: got %h expected 3c", rxLog[rxLog.size()-1]); else passed++;
        checks++; if (errCount - e0 !== 0) $display("[TB] FAIL b2b_err_count: got %0d expected 0", errCount - e0); else passed++;
    endtask

    task automatic test_glitch();
        int d0 = doneCount;
        int e0 = errCount;
        sendBit(1'b0, 3);
        sendBit(1'b1, 20);
        checks++; if (doneCount - d0 !== 0) $display("[TB] FAIL glitch_done: got %0d expected 0", doneCount - d0); else passed++;
        checks++; if (errCount - e0 !== 0) $display("[TB] FAIL glitch_err: got %0d expected 0", errCount - e0); else passed++;
        sendFrame(8'h81, 1'b0);
        waitTicks(2);
        checks++; if (doneCount - d0 !== 1) $display("[TB] FAIL glitch_next_count: got %0d expected 1", doneCount - d0); else passed++;
        checks++; if (lastData !== 8'h81) $display("[TB] FAIL glitch_next_data: got %h expected 81", lastData); else passed++;
    endtask

    task automatic test_frame_error();
        int d0 = doneCount;
        int e0 = errCount;
        sendFrame(8'h0F, 1'b1);
        waitTicks(40);
        checks++; if (errCount - e0 !== 1) $display("[TB] FAIL ferr_err_count: got %0d expected 1", errCount - e0); else passed++;
        checks++; if (doneCount - d0 !== 0) $display("[TB] FAIL ferr_done_count: got %0d expected 0", doneCount - d0); else passed++;
        checks++; if (oData !== 8'h81) $display("[TB] FAIL ferr_data_kept: got %h expected 81", oData); else passed++;
        sendBit(1'b1, 16);
        checks++; if (errCount - e0 !== 1) $display("[TB] FAIL ferr_after_break: got %0d expected 1", errCount - e0); else passed++;
        sendFrame(8'hF0, 1'b0);
        waitTicks(2);
        checks++; if (doneCount - d0 !== 1) $display("[TB] FAIL ferr_next_count: got %0d expected 1", doneCount - d0); else passed++;
        checks++; if (lastData !== 8'hF0) $display("[TB] FAIL ferr_next_data: got %h expected f0", lastData); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int d0 = doneCount;
        int e0 = errCount;
        logic [DATA_BITS-1:0] data = 8'h99;
        sendBit(1'b0, 16);
        for (int i = 0; i < 4; i++) sendBit(data[i], 16);
        sendBit(data[4], 8);
        @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (oData !== 8'h00) $display("[TB] FAIL rstmid_data: got %h expected 00", oData); else passed++;
        reset = 1'b0;
        waitTicks(30);
        checks++; if (doneCount - d0 !== 0) $display("[TB] FAIL rstmid_done: got %0d expected 0", doneCount - d0); else passed++;
        checks++; if (errCount - e0 !== 0) $display("[TB] FAIL rstmid_err: got %0d expected 0", errCount - e0); else passed++;
        sendFrame(8'h42, 1'b0);
        waitTicks(2);
        checks++; if (doneCount - d0 !== 1) $display("[TB] FAIL rstmid_next_count: got %0d expected 1", doneCount - d0); else passed++;
        checks++; if (oData !== 8'h42) $display("[TB] FAIL rstmid_next_data: got %h expected 42", oData); else passed++;
    endtask

    task automatic test_tick_freeze();
        int d0 = doneCount;
        int startTick;
        logic [DATA_BITS-1:0] data = 8'hC3;
        @(negedge clock);
        rx = 1'b0;
        startTick = tickCount;
        waitTicks(16);
        for (int i = 0; i < 3; i++) sendBit(data[i], 16);
        sendBit(data[3], 8);
        @(negedge clock);
        tickEn = 1'b0;
        repeat (1000) @(negedge clock);
        checks++; if (doneCount - d0 !== 0) $display("[TB] FAIL freeze_no_done: got %0d expected 0", doneCount - d0); else passed++;
        tickEn = 1'b1;
        waitTicks(8);
        for (int i = 4; i < DATA_BITS; i++) sendBit(data[i], 16);
        sendBit(1'b1, STOP_TICKS);
        waitTicks(2);
        checks++; if (doneCount - d0 !== 1) $display("[TB] FAIL freeze_done_count: got %0d expected 1", doneCount - d0); else passed++;
        checks++; if (lastData !== 8'hC3) $display("[TB] FAIL freeze_data: got %h expected c3", lastData); else passed++;
        checks++; if (doneTick - startTick !== LATENCY) $display("[TB] FAIL freeze_latency: got %0d ticks expected %0d", doneTick - startTick, LATENCY); else passed++;
    endtask

    task automatic test_pulse_integrity();
        checks++; if (bothHigh !== 0) $display("[TB] FAIL pulse_overlap: got %0d cycles expected 0", bothHigh); else passed++;
        checks++; if (widePulse !== 0) $display("[TB] FAIL pulse_width: got %0d wide pulses expected 0", widePulse); else passed++;
        checks++; if (dataGlitch !== 0) $display("[TB] FAIL data_stability: got %0d changes expected 0", dataGlitch); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_tick_freeze();
        test_pulse_integrity();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
